dual_servo_pwm_generator: RTL

//   Converts the two 10-bit servo position words (xPWM, yPWM) from the UART servo-select stage into two

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_pwm_channel.sv | 61 ++++++
 rtl/dual_servo_pwm_generator.sv | 90 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared types, default timing constants and helpers for the dual servo PWM generator.
package servo_pkg;

  localparam int unsigned POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t        POS_CENTER = 10'd512;
  localparam int unsigned POS_MAX    = (1 << POS_W) - 1;

  // 20 ms frame, 1.0 ms minimum pulse, ~1 us per LSB at 50 MHz.
  localparam int unsigned DEF_FRAME_CYCLES = 1_000_000;
  localparam int unsigned DEF_MIN_CYCLES   = 50_000;
  localparam int unsigned DEF_STEP_CYCLES  = 49;

  // Width of the frame counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned frame_cycles);
    return (frame_cycles > 1) ? $clog2(frame_cycles) : 1;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: 2-flop synchroniser, two-cycle stability filter,
// pending/active position registers and the registered pulse comparator.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_CYCLES  = DEF_MIN_CYCLES,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter pos_t        RESET_VALUE = POS_CENTER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos_i,       // asynchronous position word
  input  logic             boundary_i,  // last cycle of the frame: load pending into active
  input  logic             en_d_i,      // enable latch value for the next cycle
  input  logic [CNT_W-1:0] count_d_i,   // frame counter value for the next cycle
  output logic             servo_o,
  output logic [POS_W-1:0] active_o
);

  pos_t             sync1_q, sync2_q, stab_q, pending_q, active_q;
  pos_t             active_d;
  logic [CNT_W-1:0] width_d;
  logic             servo_q;

  // Next active position and the pulse width it implies for the coming cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here unconditionally)
    // so no latch can be inferred.
    active_d = boundary_i ? pending_q : active_q;
    width_d  = CNT_W'(MIN_CYCLES) + CNT_W'(active_d) * CNT_W'(STEP_CYCLES);
  end

  // Synchronise, filter, hold the position and register the pin so it rises with frameStart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      stab_q    <= RESET_VALUE;
      pending_q <= RESET_VALUE;
      active_q  <= RESET_VALUE;
      servo_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift one stage per clock;
      // blocking ones would collapse the synchroniser into a single flop.
      sync1_q  <= pos_i;
      sync2_q  <= sync1_q;
      stab_q   <= sync2_q;
      // Accept only a word seen on two consecutive cycles after synchronisation.
      if (sync2_q == stab_q) begin
        pending_q <= sync2_q;
      end
      active_q <= active_d;
      servo_q  <= en_d_i && (count_d_i < width_d);
    end
  end

  assign servo_o  = servo_q;
  assign active_o = active_q;

endmodule

// File: rtl/dual_servo_pwm_generator.sv
// Two hobby-servo PWM outputs sharing one frame counter; positions and the
// enable are applied only at frame boundaries so frames are never cut short.
module dual_servo_pwm_generator
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned MIN_CYCLES   = DEF_MIN_CYCLES,
  parameter int unsigned STEP_CYCLES  = DEF_STEP_CYCLES,
  parameter pos_t        RESET_VALUE  = POS_CENTER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [POS_W-1:0] xPWM,
  input  logic [POS_W-1:0] yPWM,
  output logic             xServo,
  output logic             yServo,
  output logic             frameStart,
  output logic [POS_W-1:0] xActive,
  output logic [POS_W-1:0] yActive
);

  localparam int unsigned      CNT_W = cnt_width(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_CYCLES - 1);

  // The widest pulse must end before the frame does.
  if (FRAME_CYCLES <= MIN_CYCLES + POS_MAX * STEP_CYCLES) begin : g_bad_timing
    $error("FRAME_CYCLES must exceed MIN_CYCLES + 1023*STEP_CYCLES");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             boundary;
  logic             en_q, en_d;
  logic             frame_start_q;

  // Frame counter wrap and enable sampling at the boundary.
  always_comb begin
    boundary = (count_q == LAST);
    count_d  = boundary ? '0 : count_q + CNT_W'(1);
    en_d     = boundary ? enable : en_q;
  end

  // Shared frame state; frameStart is high while the counter reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      en_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      en_q          <= en_d;
      frame_start_q <= boundary;
    end
  end

  servo_pwm_channel #(
    .CNT_W       (CNT_W),
    .MIN_CYCLES  (MIN_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .RESET_VALUE (RESET_VALUE)
  ) u_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .pos_i      (xPWM),
    .boundary_i (boundary),
    .en_d_i     (en_d),
    .count_d_i  (count_d),
    .servo_o    (xServo),
    .active_o   (xActive)
  );

  servo_pwm_channel #(
    .CNT_W       (CNT_W),
    .MIN_CYCLES  (MIN_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .RESET_VALUE (RESET_VALUE)
  ) u_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .pos_i      (yPWM),
    .boundary_i (boundary),
    .en_d_i     (en_d),
    .count_d_i  (count_d),
    .servo_o    (yServo),
    .active_o   (yActive)
  );

  assign frameStart = frame_start_q;

endmodule
